// File: rtl/saradc_pkg.sv
// Shared types and constants for the SAR ADC controller: FSM states, output
// flag bundle, parameter limits and the parameter-range check.
package saradc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SAMPLE = 3'd1,
      ST_STROBE = 3'd2,
      ST_DECIDE = 3'd3,
      ST_DONE   = 3'd4
   } sar_state_t;

   localparam int NBIT_MAX       = 16;
   localparam int SAMPLE_CYC_MAX = 15;
   localparam int AVG_LOG2_MAX   = 4;

   typedef struct packed {
      logic busy;
      logic sample;
      logic cmp_en;
      logic done;
   } sar_flags_t;

   function automatic logic params_ok(input int nbit, input int sample_cyc, input int avg_log2);
      return (nbit >= 2) && (nbit <= NBIT_MAX) &&
             (sample_cyc >= 1) && (sample_cyc <= SAMPLE_CYC_MAX) &&
             (avg_log2 >= 0) && (avg_log2 <= AVG_LOG2_MAX);
   endfunction

   // Output flags that must be visible while the FSM sits in a given state.
   function automatic sar_flags_t state_flags(input sar_state_t st);
      sar_flags_t f;
      f.busy   = 1'b0;
      f.sample = 1'b0;
      f.cmp_en = 1'b0;
      f.done   = 1'b0;
      case (st)
         ST_SAMPLE: begin
            f.busy   = 1'b1;
            f.sample = 1'b1;
         end
         ST_STROBE: begin
            f.busy   = 1'b1;
            f.cmp_en = 1'b1;
         end
         ST_DECIDE: f.busy = 1'b1;
         ST_DONE:   f.done = 1'b1;
         default:   f.busy = 1'b0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/saradc_sar_reg.sv
// Binary-search trial register: holds the current DAC code and the pointer to
// the bit under test. result is the code with the tested bit resolved by cmp.
module saradc_sar_reg
   import saradc_pkg::*;
#(
   parameter int NBIT = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            init,
   input  logic            clear,
   input  logic            decide,
   input  logic            cmp,
   output logic [NBIT-1:0] code,
   output logic [NBIT-1:0] result,
   output logic            last
);

   localparam int IW = $clog2(NBIT);

   logic [NBIT-1:0] code_r;
   logic [IW-1:0]   idx_r;
   logic [NBIT-1:0] resolved_s;
   logic [NBIT-1:0] step_s;
   logic            idx_zero_s;

   assign idx_zero_s = (idx_r == {IW{1'b0}});

   // Resolve the bit under test, then arm the next lower bit when one remains.
   always_comb begin
      resolved_s        = code_r;
      resolved_s[idx_r] = cmp;
      step_s            = resolved_s;
      if (!idx_zero_s) begin
         step_s[idx_r - IW'(1'b1)] = 1'b1;
      end else begin
         step_s = resolved_s;
      end
   end

   // Trial code and bit pointer; clear wins over init, init over decide.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         code_r <= {NBIT{1'b0}};
         idx_r  <= {IW{1'b0}};
      end else if (init) begin
         code_r <= {1'b1, {(NBIT-1){1'b0}}};
         idx_r  <= IW'(NBIT - 1);
      end else if (decide) begin
         code_r <= step_s;
         idx_r  <= idx_zero_s ? idx_r : (idx_r - IW'(1'b1));
      end else begin
         code_r <= code_r;
         idx_r  <= idx_r;
      end
   end

   assign code   = code_r;
   assign result = resolved_s;
   assign last   = idx_zero_s;

endmodule

// File: rtl/saradc_sar_ctrl.sv
// SAR ADC conversion controller: sampling, per-bit strobes, result and DONE.
// Optional averaging over 2^AVG_LOG2 conversions is built with SARADC_AVG_EN.
module saradc_sar_ctrl
   import saradc_pkg::*;
#(
   parameter int NBIT       = 8,
   parameter int SAMPLE_CYC = 2,
   parameter int AVG_LOG2   = 0
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            START,
   input  logic            CMP_OUT,
   output logic            BUSY,
   output logic            SAMPLE,
   output logic            CMP_EN,
   output logic [NBIT-1:0] DACP,
   output logic [NBIT-1:0] DOUT,
   output logic            DONE
);

   localparam logic       PARAMS_OK = params_ok(NBIT, SAMPLE_CYC, AVG_LOG2);
   localparam logic [3:0] SCNT_INIT = 4'(SAMPLE_CYC - 1);

   if (!PARAMS_OK) begin : g_param_err
      $error("saradc_sar_ctrl: parameter out of range");
   end

   sar_state_t      state_r;
   sar_flags_t      flags_r;
   logic [3:0]      scnt_r;
   logic [NBIT-1:0] dout_r;

   logic            accept_s;
   logic            finish_s;
   logic            set_last_s;
   logic            reg_init_s;
   logic            reg_clear_s;
   logic            reg_decide_s;
   logic            last_s;
   logic [NBIT-1:0] code_s;
   logic [NBIT-1:0] result_s;
   logic [NBIT-1:0] final_s;

   // Control strobes for the trial register, derived from the current state.
   always_comb begin
      accept_s     = START && ((state_r == ST_IDLE) || (state_r == ST_DONE));
      finish_s     = (state_r == ST_DECIDE) && last_s;
      reg_init_s   = accept_s || (finish_s && !set_last_s);
      reg_clear_s  = finish_s && set_last_s;
      reg_decide_s = (state_r == ST_DECIDE);
   end

   saradc_sar_reg #(.NBIT(NBIT)) u_sar_reg (
      .clk    (CLK),
      .rst    (RST),
      .init   (reg_init_s),
      .clear  (reg_clear_s),
      .decide (reg_decide_s),
      .cmp    (CMP_OUT),
      .code   (code_s),
      .result (result_s),
      .last   (last_s)
   );

`ifdef SARADC_AVG_EN
   localparam int AW = NBIT + AVG_LOG2;

   logic [AW-1:0] acc_r;
   logic [AW-1:0] acc_sum_s;
   logic [AW-1:0] avg_s;
   logic [4:0]    conv_r;

   assign acc_sum_s  = acc_r + AW'(result_s);
   assign avg_s      = acc_sum_s >> AVG_LOG2;
   assign set_last_s = (conv_r == 5'((1 << AVG_LOG2) - 1));
   assign final_s    = avg_s[NBIT-1:0];

   // Accumulator and conversion count for one averaging set.
   always_ff @(posedge CLK) begin
      if (RST || accept_s) begin
         acc_r  <= {AW{1'b0}};
         conv_r <= 5'd0;
      end else if (finish_s) begin
         acc_r  <= set_last_s ? {AW{1'b0}} : acc_sum_s;
         conv_r <= set_last_s ? 5'd0 : (conv_r + 5'd1);
      end else begin
         acc_r  <= acc_r;
         conv_r <= conv_r;
      end
   end
`else
   assign set_last_s = 1'b1;
   assign final_s    = result_s;
`endif

   // Main FSM; output flags are registered alongside the state they belong to.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= ST_IDLE;
         flags_r <= state_flags(ST_IDLE);
         scnt_r  <= 4'd0;
         dout_r  <= {NBIT{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (START) begin
                  state_r <= ST_SAMPLE;
                  flags_r <= state_flags(ST_SAMPLE);
                  scnt_r  <= SCNT_INIT;
               end else begin
                  state_r <= ST_IDLE;
                  flags_r <= state_flags(ST_IDLE);
               end
            end
            ST_SAMPLE: begin
               if (scnt_r == 4'd0) begin
                  state_r <= ST_STROBE;
                  flags_r <= state_flags(ST_STROBE);
               end else begin
                  scnt_r  <= scnt_r - 4'd1;
                  flags_r <= state_flags(ST_SAMPLE);
               end
            end
            ST_STROBE: begin
               state_r <= ST_DECIDE;
               flags_r <= state_flags(ST_DECIDE);
            end
            ST_DECIDE: begin
               if (!last_s) begin
                  state_r <= ST_STROBE;
                  flags_r <= state_flags(ST_STROBE);
               end else if (set_last_s) begin
                  state_r <= ST_DONE;
                  flags_r <= state_flags(ST_DONE);
                  dout_r  <= final_s;
               end else begin
                  // more conversions in the averaging set: resample immediately
                  state_r <= ST_SAMPLE;
                  flags_r <= state_flags(ST_SAMPLE);
                  scnt_r  <= SCNT_INIT;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               flags_r <= state_flags(ST_IDLE);
            end
         endcase
      end
   end

   assign BUSY   = flags_r.busy;
   assign SAMPLE = flags_r.sample;
   assign CMP_EN = flags_r.cmp_en;
   assign DONE   = flags_r.done;
   assign DACP   = code_s;
   assign DOUT   = dout_r;

endmodule
